// File: rtl/tmr_counter.sv
// Timer count stage: 4-bit prescaler feeding an 8-bit up/down counter with wrap pulses.
// Optional debug freeze input enabled by defining COUNTER_HALT_EN.
module tmr_counter (
    input  logic       cnt_clk,
    input  logic       cnt_reset,
    input  logic       cnt_load,
    input  logic       cnt_up_down,
    input  logic       cnt_en,
    input  logic [1:0] cnt_cks,
`ifdef COUNTER_HALT_EN
    input  logic       cnt_halt,
`endif
    input  logic [7:0] cnt_tdr,
    output logic [7:0] cnt_tcnt,
    output logic       cnt_ovf,
    output logic       cnt_udf
);

    logic [3:0] presc;
    logic [3:0] tick_mask;
    logic       tick;
    logic       halt;

`ifdef COUNTER_HALT_EN
    assign halt = cnt_halt;
`else
    assign halt = 1'b0;
`endif

    // Tick fires when the low (cks+1) prescaler bits are all ones.
    always_comb begin
        tick_mask = 4'h1;
        unique case (cnt_cks)
            2'b00: tick_mask = 4'h1;
            2'b01: tick_mask = 4'h3;
            2'b10: tick_mask = 4'h7;
            2'b11: tick_mask = 4'hF;
        endcase
    end

    assign tick = ((presc & tick_mask) == tick_mask);

    always_ff @(posedge cnt_clk) begin
        if (cnt_reset) begin
            presc    <= 4'h0;
            cnt_tcnt <= 8'h00;
            cnt_ovf  <= 1'b0;
            cnt_udf  <= 1'b0;
        end else if (cnt_load) begin
            presc    <= 4'h0;
            cnt_tcnt <= cnt_tdr;
            cnt_ovf  <= 1'b0;
            cnt_udf  <= 1'b0;
        end else if (halt) begin
            cnt_ovf <= 1'b0;
            cnt_udf <= 1'b0;
        end else if (!cnt_en) begin
            presc   <= 4'h0;
            cnt_ovf <= 1'b0;
            cnt_udf <= 1'b0;
        end else begin
            presc   <= presc + 4'd1;
            cnt_ovf <= 1'b0;
            cnt_udf <= 1'b0;
            if (tick) begin
                if (!cnt_up_down) begin
                    cnt_tcnt <= cnt_tcnt + 8'd1;
                    cnt_ovf  <= (cnt_tcnt == 8'hFF);
                end else begin
                    cnt_tcnt <= cnt_tcnt - 8'd1;
                    cnt_udf  <= (cnt_tcnt == 8'h00);
                end
            end
        end
    end

endmodule

// File: tb/tb_tmr_counter.sv
// Self-checking bench for tmr_counter: per-cycle scoreboard against a behavioural model,
// a table of directed vectors, and hand-written multi-cycle corner sequences.
module tb_tmr_counter;

    logic       clk = 1'b0;
    logic       reset, load, up_down, en, halt;
    logic [1:0] cks;
    logic [7:0] tdr;
    logic [7:0] tcnt;
    logic       ovf, udf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] sb_q[$];
    logic [7:0] m_tcnt;
    logic [3:0] m_presc;
    logic       m_ovf, m_udf;

    typedef struct {
        logic       load;
        logic       ud;
        logic       en;
        logic [1:0] cks;
        logic [7:0] tdr;
        int         reps;
        logic [7:0] e_tcnt;
        logic       e_ovf;
        logic       e_udf;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    tmr_counter dut (
        .cnt_clk     (clk),
        .cnt_reset   (reset),
        .cnt_load    (load),
        .cnt_up_down (up_down),
        .cnt_en      (en),
        .cnt_cks     (cks),
`ifdef COUNTER_HALT_EN
        .cnt_halt    (halt),
`endif
        .cnt_tdr     (tdr),
        .cnt_tcnt    (tcnt),
        .cnt_ovf     (ovf),
        .cnt_udf     (udf)
    );

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got tcnt=%h ovf=%b udf=%b, expected tcnt=%h ovf=%b udf=%b",
                     name, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // Reference model: divide period is 2^(cks+1); tick when presc sits one short of it.
    task automatic model_edge();
        int period;
        logic tk;
        period = 2 << cks;
        tk = ((int'(m_presc) % period) == period - 1);
        if (reset) begin
            m_tcnt = 8'h00; m_presc = 4'h0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (load) begin
            m_tcnt = tdr; m_presc = 4'h0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (halt) begin
            m_ovf = 1'b0; m_udf = 1'b0;
        end else if (!en) begin
            m_presc = 4'h0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            m_ovf = 1'b0; m_udf = 1'b0;
            if (tk) begin
                if (!up_down) begin
                    m_ovf  = (m_tcnt == 8'hFF);
                    m_tcnt = m_tcnt + 8'd1;
                end else begin
                    m_udf  = (m_tcnt == 8'h00);
                    m_tcnt = m_tcnt - 8'd1;
                end
            end
            m_presc = m_presc + 4'd1;
        end
        sb_q.push_back({m_tcnt, m_ovf, m_udf});
    endtask

    task automatic cycle(input int n);
        logic [9:0] exp;
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            check("scoreboard", {tcnt, ovf, udf}, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic ud, input logic e,
                         input logic [1:0] ck, input logic [7:0] d);
        load = ld; up_down = ud; en = e; cks = ck; tdr = d;
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        m_tcnt = 8'hXX; m_presc = 4'hX; m_ovf = 1'bX; m_udf = 1'bX;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8'hFE, 1,   8'hFE, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 2,   8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 2,   8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 1,   8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b01, 8'h01, 1,   8'h01, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h00, 4,   8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b01, 8'h00, 4,   8'hFF, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'b11, 8'h00, 1,   8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 16,  8'h01, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 240, 8'h10, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 2'b00, 8'h55, 3,   8'h55, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 2'b00, 8'hAA, 1,   8'hAA, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 2,   8'hAA, 1'b0, 1'b0};

        // Reset state
        cycle(2);
        check("reset_state", {tcnt, ovf, udf}, {8'h00, 1'b0, 1'b0});
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].load, vecs[k].ud, vecs[k].en, vecs[k].cks, vecs[k].tdr);
            cycle(vecs[k].reps);
            check($sformatf("vec%0d", k), {tcnt, ovf, udf},
                  {vecs[k].e_tcnt, vecs[k].e_ovf, vecs[k].e_udf});
        end

        // Reset mid-count with en held high
        drive(1'b1, 1'b0, 1'b1, 2'b00, 8'h35);
        cycle(1);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
        cycle(4);
        check("count_to_37", {tcnt, ovf, udf}, {8'h37, 1'b0, 1'b0});
        reset = 1'b1;
        cycle(1);
        check("reset_mid", {tcnt, ovf, udf}, {8'h00, 1'b0, 1'b0});
        reset = 1'b0;
        cycle(1);
        check("restart_e1", {tcnt, ovf, udf}, {8'h00, 1'b0, 1'b0});
        cycle(1);
        check("restart_e2", {tcnt, ovf, udf}, {8'h01, 1'b0, 1'b0});

        // Reset clears an in-flight overflow pulse
        drive(1'b1, 1'b0, 1'b1, 2'b00, 8'hFF);
        cycle(1);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
        cycle(2);
        check("ovf_pulse", {tcnt, ovf, udf}, {8'h00, 1'b1, 1'b0});
        reset = 1'b1;
        cycle(1);
        check("reset_clr_ovf", {tcnt, ovf, udf}, {8'h00, 1'b0, 1'b0});
        reset = 1'b0;

        // Clock-select switch with presc=3: next tick on the very next edge
        drive(1'b1, 1'b0, 1'b0, 2'b11, 8'h00);
        cycle(1);
        drive(1'b0, 1'b0, 1'b1, 2'b11, 8'h00);
        cycle(3);
        check("cks11_p3", {tcnt, ovf, udf}, {8'h00, 1'b0, 1'b0});
        cks = 2'b00;
        cycle(1);
        check("cks_switch", {tcnt, ovf, udf}, {8'h01, 1'b0, 1'b0});

        // Single-cycle en drop restarts the full /4 period
        drive(1'b1, 1'b0, 1'b0, 2'b01, 8'h20);
        cycle(1);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 8'h00);
        cycle(3);
        en = 1'b0;
        cycle(1);
        en = 1'b1;
        cycle(3);
        check("en_drop_3", {tcnt, ovf, udf}, {8'h20, 1'b0, 1'b0});
        cycle(1);
        check("en_drop_4", {tcnt, ovf, udf}, {8'h21, 1'b0, 1'b0});

`ifdef COUNTER_HALT_EN
        // Halt freezes presc=2, tcnt=10; release needs exactly 2 edges to tick
        drive(1'b1, 1'b0, 1'b0, 2'b01, 8'h10);
        cycle(1);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 8'h00);
        cycle(2);
        halt = 1'b1;
        cycle(5);
        check("halt_hold", {tcnt, ovf, udf}, {8'h10, 1'b0, 1'b0});
        halt = 1'b0;
        cycle(1);
        check("halt_rel_1", {tcnt, ovf, udf}, {8'h10, 1'b0, 1'b0});
        cycle(1);
        check("halt_rel_2", {tcnt, ovf, udf}, {8'h11, 1'b0, 1'b0});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
